// File: rtl/rr_stream_mux.sv
// rr_stream_mux: CH-input stream multiplexer with a registered output stage.
// Selects one input channel per cycle and forwards it through a single
// valid/ready output register. Two selection modes are supported:
//   mode = 0 : always selects the fixed channel s
//   mode = 1 : round-robin over the valid channels, starting after the last
//              accepted channel
// Optional feature (macro RR_STREAM_MUX_PKT_LOCK_EN): adds packet locking.
// Once a beat with last = 0 is accepted from a channel, the selection stays
// on that channel until its beat with last = 1 is accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    CH*WIDTH bits; channel k occupies bits [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational from the grant and load)
//   in_last    per-channel end of packet (RR_STREAM_MUX_PKT_LOCK_EN only)
//   mode       0 = fixed channel s, 1 = round-robin
//   s          fixed-select channel used in mode 0
//   out_data   registered data
//   out_ch     source channel of out_data
//   out_valid  out_data is valid
//   out_last   registered last flag (RR_STREAM_MUX_PKT_LOCK_EN only)
//   out_ready  downstream accepts out_data
module rr_stream_mux #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned CH    = 4,
   localparam int unsigned SELW  = $clog2(CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH*WIDTH-1:0]   in_data,
   input  logic [CH-1:0]         in_valid,
   output logic [CH-1:0]         in_ready,
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
   input  logic [CH-1:0]         in_last,
   output logic                  out_last,
`endif
   input  logic                  mode,
   input  logic [SELW-1:0]       s,
   output logic [WIDTH-1:0]      out_data,
   output logic [SELW-1:0]       out_ch,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  g_rr;
   logic [SELW-1:0]  g;
   logic [WIDTH-1:0] g_data;
   logic             load;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
   logic             lock;
   logic [SELW-1:0]  lock_ch;
`endif

   // Output register may take a new beat when empty or being drained.
   assign load = !out_valid || out_ready;

   // Round-robin search: first valid channel at ptr+1, ptr+2, ... ptr+CH.
   // Scanning from the farthest offset down lets the nearest one win.
   // With nothing valid the grant idles on ptr+1, which carries no transfer.
   always_comb begin
      g_rr = ptr + SELW'(1);
      for (int off = int'(CH); off >= 1; off--) begin
         if (in_valid[ptr + SELW'(off)]) begin
            g_rr = ptr + SELW'(off);
         end
      end
   end

   // Final grant: packet lock overrides both modes.
   always_comb begin
      g = mode ? g_rr : s;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      if (lock) begin
         g = lock_ch;
      end
`endif
   end

   // Data of the granted channel.
   always_comb begin
      g_data = '0;
      for (int k = 0; k < int'(CH); k++) begin
         if (g == SELW'(k)) begin
            g_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot ready on the granted channel; held low throughout reset.
   always_comb begin
      in_ready = '0;
      for (int k = 0; k < int'(CH); k++) begin
         in_ready[k] = load && !rst && (g == SELW'(k));
      end
   end

   // Output stage, round-robin pointer and packet lock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= SELW'(CH - 1);
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
         out_last  <= 1'b0;
         lock      <= 1'b0;
         lock_ch   <= '0;
`endif
      end else if (load) begin
         if (in_valid[g]) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            out_ch    <= g;
            ptr       <= g;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
            out_last  <= in_last[g];
            lock      <= !in_last[g];
            lock_ch   <= g;
`endif
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Testbench for rr_stream_mux (WIDTH=8, CH=4): directed vectors with literal
// expectations plus a per-cycle comparison against a transaction-level model.
module tb_rr_stream_mux;

   localparam int W  = 8;
   localparam int CH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH*W-1:0] in_data = '0;
   logic [CH-1:0] in_valid = '0;
   logic [CH-1:0] in_ready;
   logic          mode = 1'b0;
   logic [1:0]    s = '0;
   logic [W-1:0]  out_data;
   logic [1:0]    out_ch;
   logic          out_valid;
   logic          out_ready = 1'b0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
   logic [CH-1:0] in_last = '0;
   logic          out_last;
`endif

   int checks = 0;
   int errors = 0;

   rr_stream_mux #(.WIDTH(W), .CH(CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .mode      (mode),
      .s         (s),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: a queue-free view of the mux contract ----------
   logic         m_valid = 1'b0;
   logic [W-1:0] m_data  = '0;
   int           m_ch    = 0;
   int           m_ptr   = CH - 1;
   logic         m_lock  = 1'b0;
   int           m_lock_ch = 0;
   logic         m_last  = 1'b0;

   // Selected channel by the rules; -1 when round-robin finds nothing valid.
   function automatic int grant();
      if (m_lock) return m_lock_ch;
      if (!mode) return int'(s);
      for (int off = 1; off <= CH; off++) begin
         if (in_valid[(m_ptr + off) % CH]) return (m_ptr + off) % CH;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      int g;
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = CH - 1;
         m_lock = 1'b0; m_lock_ch = 0; m_last = 1'b0;
      end else if (!m_valid || out_ready) begin
         g = grant();
         if (g >= 0 && in_valid[g]) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_ch    = g;
            m_ptr   = g;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
            m_last    = in_last[g];
            m_lock    = !in_last[g];
            m_lock_ch = g;
`endif
         end else begin
            m_valid = 1'b0;
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      int g;
      logic [CH-1:0] exp_rdy;
      if (rst) begin
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_in_ready", 32'(in_ready), 32'd0);
      end else begin
         chk("model_out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) begin
            chk("model_out_data", 32'(out_data), 32'(m_data));
            chk("model_out_ch", 32'(out_ch), 32'(m_ch));
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
            chk("model_out_last", 32'(out_last), 32'(m_last));
`endif
         end
         g = grant();
         if (g >= 0) begin
            exp_rdy = (!m_valid || out_ready) ? CH'(1 << g) : '0;
            chk("model_in_ready", 32'(in_ready), 32'(exp_rdy));
         end
      end
   end

   task automatic set_ch(input int k, input logic [W-1:0] d);
      in_data[k*W +: W] = d;
   endtask

   // ---------------- directed stimulus ------------------------------------
   initial begin
      // reset state
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data", 32'(out_data), 32'd0);
      chk("reset_out_ch", 32'(out_ch), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      #2 rst = 1'b0;

      // fixed select of channel 2
      @(negedge clk); #1;
      mode = 1'b0; s = 2'd2; in_valid = 4'b0100; set_ch(2, 8'hA5); out_ready = 1'b1;
      @(negedge clk);
      chk("fixed_in_ready", 32'(in_ready), 32'h4);
      @(negedge clk);
      chk("fixed_out_valid", 32'(out_valid), 32'd1);
      chk("fixed_out_data", 32'(out_data), 32'hA5);
      chk("fixed_out_ch", 32'(out_ch), 32'd2);
      #1 in_valid = '0;

      // round-robin from reset
      @(negedge clk); #2 rst = 1'b1;
      @(negedge clk); #2 rst = 1'b0;
      mode = 1'b1; in_valid = 4'b1111;
      for (int k = 0; k < CH; k++) set_ch(k, 8'(8'h10 + k));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rr_out_valid", 32'(out_valid), 32'd1);
         chk("rr_out_ch", 32'(out_ch), 32'(i % 4));
      end

      // last grant 0, channels 0 and 3 valid
      #1 in_valid = 4'b1001;
      @(negedge clk);
      chk("rr_skip_ch3", 32'(out_ch), 32'd3);
      @(negedge clk);
      chk("rr_wrap_ch0", 32'(out_ch), 32'd0);
      #1 in_valid = '0;
      @(negedge clk); #1;

      // back-pressure hold
      mode = 1'b0; s = 2'd1; in_valid = 4'b0010; set_ch(1, 8'h11); out_ready = 1'b0;
      @(negedge clk);
      chk("bp_first_ch", 32'(out_ch), 32'd1);
      #1 in_valid = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         s = 2'(i); set_ch(i, 8'(8'hC0 + i)); set_ch(1, 8'(8'h77 + i));
         @(negedge clk);
         chk("bp_hold_data", 32'(out_data), 32'h11);
         chk("bp_hold_ch", 32'(out_ch), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         #1;
      end
      s = 2'd3; set_ch(3, 8'h33); out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(in_ready), 32'h8);
      @(negedge clk);
      chk("bp_new_data", 32'(out_data), 32'h33);
      chk("bp_new_ch", 32'(out_ch), 32'd3);

      // reset while a beat is held
      #1 out_ready = 1'b0; in_valid = 4'b1000;
      @(negedge clk);
      chk("held_before_rst", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", 32'(out_valid), 32'd0);
      chk("rst_async_ready", 32'(in_ready), 32'd0);
      @(negedge clk); #2 rst = 1'b0;
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_rr_ch0", 32'(out_ch), 32'd0);
      chk("post_rst_valid", 32'(out_valid), 32'd1);

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      // packet lock: channel 1 sends three beats while channel 2 stays valid
      #1 in_valid = '0;
      @(negedge clk); #2 rst = 1'b1;
      @(negedge clk); #2 rst = 1'b0;
      mode = 1'b1; in_valid = 4'b0110; in_last = '0; out_ready = 1'b1;
      @(negedge clk);
      chk("lock_b1_ch", 32'(out_ch), 32'd1);
      chk("lock_b1_last", 32'(out_last), 32'd0);
      @(negedge clk);
      chk("lock_b2_ch", 32'(out_ch), 32'd1);
      chk("lock_b2_last", 32'(out_last), 32'd0);
      #1 in_last = 4'b0010;
      @(negedge clk);
      chk("lock_b3_ch", 32'(out_ch), 32'd1);
      chk("lock_b3_last", 32'(out_last), 32'd1);
      #1 in_valid = 4'b0100; in_last = '0;
      @(negedge clk);
      chk("lock_next_ch", 32'(out_ch), 32'd2);
`endif

      // randomised traffic, checked by the model every cycle
      #1;
      for (int i = 0; i < 300; i++) begin
         mode      = 1'($urandom_range(0, 1));
         s         = 2'($urandom_range(0, 3));
         in_valid  = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = 32'($urandom);
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
         in_last   = 4'($urandom_range(0, 15));
`endif
         @(posedge clk); #1;
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the data bits per channel.
REQ-002 The block SHALL have a parameter CH, default 4, giving the channel count; legal values are powers of two from 2 to 16.
REQ-003 The block SHALL have a localparam SELW equal to log2(CH).
REQ-004 The block SHALL have a port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have a port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have a port in_data, input, CH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have a port in_valid, input, CH bits: per-channel valid.
REQ-008 The block SHALL have a port in_ready, output, CH bits: per-channel ready.
REQ-009 The block SHALL have a port mode, input, 1 bit: 0 selects fixed channel s, 1 selects round-robin.
REQ-010 The block SHALL have a port s, input, SELW bits: the fixed-select channel used in mode 0.
REQ-011 The block SHALL have a port out_data, output, WIDTH bits: registered data.
REQ-012 The block SHALL have a port out_ch, output, SELW bits: the source channel of out_data.
REQ-013 The block SHALL have a port out_valid, output, 1 bit: out_data is valid.
REQ-014 The block SHALL have a port out_ready, input, 1 bit: downstream accepts out_data.

Function
REQ-015 The block SHALL define load = !out_valid || out_ready.
REQ-016 The grant g SHALL be computed combinationally: in mode 0, g = s; in mode 1, g is the first channel with in_valid set, searching from ptr+1 upward and wrapping CH-1 to 0.
REQ-017 in_ready[k] SHALL be 1 only when k == g and load = 1; all other bits SHALL be 0.
REQ-018 On a clock edge with load = 1 and in_valid[g] = 1, the block SHALL register in_data[g] into out_data, register g into out_ch, and set out_valid = 1; latency is one cycle.
REQ-019 On a clock edge with load = 1 and no granted valid input, the block SHALL clear out_valid and hold out_data and out_ch.
REQ-020 When out_valid = 1 and out_ready = 0, out_data, out_ch and out_valid SHALL hold unchanged, regardless of changes on s, mode or the inputs.
REQ-021 The round-robin pointer ptr SHALL update to g only on an accepted input transfer; mode changes SHALL NOT modify ptr.
REQ-022 In mode 1, the block SHALL sustain full throughput of one transfer per cycle while out_ready = 1.
REQ-023 In mode 0, in_valid on any channel other than s SHALL be ignored and never dropped, since its ready stays 0.
REQ-024 A change on mode or s SHALL take effect on the next load cycle.

Reset
REQ-025 While rst = 1, the block SHALL force out_valid = 0, out_data = 0, out_ch = 0 and ptr = CH-1, so that channel 0 wins first in mode 1.
REQ-026 A reset asserted mid-transfer SHALL discard the held beat; in_ready SHALL be 0 while rst = 1.

Configuration
REQ-027 When the macro RR_STREAM_MUX_PKT_LOCK_EN is defined, the block SHALL add input in_last (CH bits) and output out_last (1 bit, reset 0, registered alongside out_data).
REQ-028 With RR_STREAM_MUX_PKT_LOCK_EN defined, once a beat with last = 0 is accepted from channel c, g SHALL be forced to c in both modes until a beat from c with last = 1 is accepted.
REQ-029 With RR_STREAM_MUX_PKT_LOCK_EN defined, reset SHALL clear the lock.
REQ-030 Without RR_STREAM_MUX_PKT_LOCK_EN, the in_last and out_last ports SHALL NOT exist, and every beat SHALL be arbitrated independently.

Verification (WIDTH=8, CH=4)
REQ-031 Mode=0, s=2, in_valid=4'b0100, channel 2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
REQ-032 Mode=1, in_valid=4'b1111, out_ready=1, starting from reset -> out_ch sequence 0,1,2,3,0 on consecutive cycles with out_valid held at 1.
REQ-033 Mode=1, last grant 0, in_valid=4'b1001 -> next grants are 3, then 0.
REQ-034 out_valid=1, out_ready=0 for 3 cycles while s and in_data toggle -> out_data and out_ch stable, in_ready=4'b0000; out_ready=1 -> new beat loaded on the same edge.
REQ-035 rst pulsed while out_valid=1 and out_ready=0 -> out_valid=0 immediately; after release, mode 1 grants channel 0 first.
REQ-036 With RR_STREAM_MUX_PKT_LOCK_EN defined: channel 1 sends 3 beats with last on beat 3 while channel 2 is valid throughout -> out_ch=1,1,1,2 and out_last=0,0,1,x.
